// File: rtl/divider_8.sv
// Iterative unsigned restoring divider: Q = A / B, R = A % B.
// One shift-and-subtract step per clock. A start/busy/done handshake
// connects it to the controlling FSM. Dividing by zero returns
// Q = all ones, R = A and sets dz.
module divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dz
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] cnt;
  logic             dz_acc;

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH:0]   trial;
  logic             accept;

  // The partial remainder is always below 2^(WIDTH-1) before it is shifted,
  // so dropping r_acc's MSB loses nothing. The trial subtract is one bit wider,
  // and its top bit is the borrow that decides whether to restore.
  assign r_shift = {r_acc[WIDTH-2:0], q_acc[WIDTH-1]};
  assign trial   = {1'b0, r_shift} - {1'b0, b_reg};

  // A new division is accepted only from IDLE or DONE. A start during RUN is ignored.
  assign accept  = start && (state == IDLE || state == DONE);

  // Datapath: latch the operands on accept, then do one restoring step per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      b_reg <= B;
      if (B == '0) begin
        q_acc <= '1;
        r_acc <= A;
      end else begin
        q_acc <= A;
        r_acc <= '0;
      end
    end else if (state == RUN) begin
      if (!trial[WIDTH]) begin
        r_acc <= trial[WIDTH-1:0];
        q_acc <= {q_acc[WIDTH-2:0], 1'b1};
      end else begin
        r_acc <= r_shift;
        q_acc <= {q_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Control FSM: iteration count, handshake outputs, and result registers committed on DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Q      <= '0;
      R      <= '0;
      dz     <= 1'b0;
      dz_acc <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DONE) begin
        done <= 1'b1;
        Q    <= q_acc;
        R    <= r_acc;
        dz   <= dz_acc;
      end
      if (accept) begin
        cnt    <= '0;
        dz_acc <= (B == '0);
        busy   <= 1'b1;
        state  <= (B == '0) ? DONE : RUN;
      end else begin
        case (state)
          RUN: begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= DONE;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider_8.sv
// Self-checking bench for divider_8: table vectors, randomized divisions
// against an arithmetic reference model, and handshake corner sequences.
module tb_divider_8;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             dz;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divider_8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .dz    (dz)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[10];

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: plain integer division, with the divide-by-zero convention.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z);
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Start one division, then check latency, results, busy, and that done is a single pulse.
  task automatic run_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int lat;
    int exp_lat;
    exp_lat = (b == 8'd0) ? 1 : WIDTH + 1;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    chk({tag, "_busy"}, int'(busy), 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 20);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_q"}, int'(Q), int'(eq));
    chk({tag, "_r"}, int'(R), int'(er));
    chk({tag, "_dz"}, int'(dz), int'(ez));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int          lat;
    int          cnt_done;
    int          held_ok;
    logic [7:0]  ra, rb, rq, rr;
    logic        rz;

    vecs[0] = '{a: 8'd200,  b: 8'd7,    q: 8'd28,   r: 8'd4,    z: 1'b0};
    vecs[1] = '{a: 8'd255,  b: 8'd1,    q: 8'd255,  r: 8'd0,    z: 1'b0};
    vecs[2] = '{a: 8'd5,    b: 8'd9,    q: 8'd0,    r: 8'd5,    z: 1'b0};
    vecs[3] = '{a: 8'h88,   b: 8'h8C,   q: 8'd0,    r: 8'h88,   z: 1'b0};
    vecs[4] = '{a: 8'd42,   b: 8'd0,    q: 8'hFF,   r: 8'd42,   z: 1'b1};
    vecs[5] = '{a: 8'd255,  b: 8'd255,  q: 8'd1,    r: 8'd0,    z: 1'b0};
    vecs[6] = '{a: 8'd0,    b: 8'd5,    q: 8'd0,    r: 8'd0,    z: 1'b0};
    vecs[7] = '{a: 8'd128,  b: 8'd128,  q: 8'd1,    r: 8'd0,    z: 1'b0};
    vecs[8] = '{a: 8'd255,  b: 8'd16,   q: 8'd15,   r: 8'd15,   z: 1'b0};
    vecs[9] = '{a: 8'd0,    b: 8'd0,    q: 8'hFF,   r: 8'd0,    z: 1'b1};

    // T1: reset for two cycles, then check the idle outputs
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q",    int'(Q), 0);
    chk("rst_r",    int'(R), 0);
    chk("rst_dz",   int'(dz), 0);

    // T2/T3/T4 and boundary vectors from the table
    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);

    // Randomized divisions against the reference model
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      ref_div(ra, rb, rq, rr, rz);
      run_check($sformatf("rnd%0d", i), ra, rb, rq, rr, rz);
    end

    // T5a: a start during RUN is ignored
    @(negedge clk);
    A = 8'd100; B = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start = 1'b1; A = 8'd9; B = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    chk("ign_lat", lat, 9);
    chk("ign_q", int'(Q), 33);
    chk("ign_r", int'(R), 1);

    // T5b: a reset in the middle of a division aborts it without a done pulse
    @(negedge clk);
    A = 8'd50; B = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_q",    int'(Q), 0);
    chk("midrst_r",    int'(R), 0);
    cnt_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
    end
    chk("midrst_no_done", cnt_done, 0);

    // T6: start raised in the DONE cycle is accepted back-to-back
    @(negedge clk);
    A = 8'd200; B = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 9) begin
        start = 1'b1; A = 8'd50; B = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("b2b_done1", int'(done), 1);
    chk("b2b_q1",    int'(Q), 28);
    chk("b2b_r1",    int'(R), 4);
    chk("b2b_busy",  int'(busy), 1);
    held_ok = 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!done && (Q !== 8'd28 || R !== 8'd4)) held_ok = 0;
    end while (!done && lat < 20);
    chk("b2b_held", held_ok, 1);
    chk("b2b_lat",  lat, 9);
    chk("b2b_q2",   int'(Q), 10);
    chk("b2b_r2",   int'(R), 0);
    chk("b2b_dz2",  int'(dz), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
